// File: rtl/cache_pkg.sv
// Shared types and line geometry for the cache controller and the memory adapter.
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int OFFSET_W       = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } adapter_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/cache_mem_adapter_if.sv
// Line-level controller handshake plus word-level main-memory bus seen by the adapter.
interface cache_mem_adapter_if #(
    parameter int WORD_W         = cache_pkg::WORD_W,
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int ADDR_W         = 32
);

    logic                               mem_read;
    logic                               mem_write;
    logic [ADDR_W-1:0]                  ca_addr;
    logic [WORDS_PER_LINE*WORD_W-1:0]   ca_wdata;
    logic [WORDS_PER_LINE*WORD_W-1:0]   ca_rdata;
    logic                               ca_resp;
    logic                               err;
    logic                               mm_req;
    logic                               mm_we;
    logic [ADDR_W-1:0]                  mm_addr;
    logic [WORD_W-1:0]                  mm_wdata;
    logic [WORD_W-1:0]                  mm_rdata;
    logic                               mm_ack;

    // The adapter masters the memory bus and answers the controller.
    modport master (
        input  mem_read, mem_write, ca_addr, ca_wdata, mm_rdata, mm_ack,
        output ca_rdata, ca_resp, err, mm_req, mm_we, mm_addr, mm_wdata
    );

    modport slave (
        output mem_read, mem_write, ca_addr, ca_wdata, mm_rdata, mm_ack,
        input  ca_rdata, ca_resp, err, mm_req, mm_we, mm_addr, mm_wdata
    );

endinterface

// File: rtl/mm_beat_timer.sv
// Beat index within a line burst and the per-beat ack timeout; both idle at zero outside a burst.
module mm_beat_timer #(
    parameter int WORDS_PER_LINE = 8,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_run,
    input  logic                              i_ack,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_beat,
    output logic                              o_last_beat,
    output logic                              o_timed_out
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [BEAT_W-1:0] r_beat;
    logic [TCNT_W-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_beat <= '0;
            r_tcnt <= '0;
        end else if (i_ack) begin
            r_beat <= r_beat + BEAT_W'(1);
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

    assign o_beat      = r_beat;
    assign o_last_beat = (r_beat == BEAT_W'(WORDS_PER_LINE - 1));
    // Fires on the TIMEOUT_CYC-th consecutive ack-less cycle of one beat.
    assign o_timed_out = i_run && !i_ack && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cache_mem_adapter.sv
// Splits a line fill / write-back into single-word main-memory transfers and returns ca_resp.
module cache_mem_adapter #(
    parameter int WORD_W         = cache_pkg::WORD_W,
    parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_adapter_if.master  bus
);

    localparam int LINE_BITS  = WORDS_PER_LINE * WORD_W;
    localparam int LINE_OFF_W = $clog2(LINE_BITS / 8);
    localparam int WORD_OFF_W = $clog2(WORD_W / 8);
    localparam int BEAT_W     = $clog2(WORDS_PER_LINE);

    import cache_pkg::*;

    adapter_state_e         r_state;
    adapter_state_e         w_state_nxt;
    op_e                    r_op;
    logic [ADDR_W-1:0]      r_base;
    logic [LINE_BITS-1:0]   r_wline;
    logic [LINE_BITS-1:0]   r_rdata;
    logic                   r_err;

    logic [BEAT_W-1:0]      w_beat;
    logic                   w_last_beat;
    logic                   w_timed_out;
    logic                   w_run;
    logic                   w_beat_done;
    logic                   w_accept_rd;
    logic                   w_accept_wr;
    logic                   w_err_set;
    logic                   w_served_req;
    logic                   w_ca_resp;

    assign w_run        = (r_state == BURST);
    assign w_beat_done  = w_run && bus.mm_ack;
    assign w_served_req = (r_op == OP_WRITE) ? bus.mem_write : bus.mem_read;

    mm_beat_timer #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TIMEOUT_CYC    (TIMEOUT_CYC)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .i_ack       (w_beat_done),
        .o_beat      (w_beat),
        .o_last_beat (w_last_beat),
        .o_timed_out (w_timed_out)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept_rd = 1'b0;
        w_accept_wr = 1'b0;
        w_err_set   = 1'b0;
        w_ca_resp   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    w_err_set = 1'b1;
                end else if (bus.mem_write) begin
                    w_accept_wr = 1'b1;
                    w_state_nxt = BURST;
                end else if (bus.mem_read) begin
                    w_accept_rd = 1'b1;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (w_beat_done && w_last_beat) begin
                    w_state_nxt = RESP;
                end else if (w_timed_out) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_ca_resp   = 1'b1;
                w_state_nxt = DRAIN;
            end
            // Hold off until the served request drops so a lingering one is not re-run.
            DRAIN: begin
                if (!w_served_req) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_READ;
            r_base  <= '0;
            r_wline <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (w_accept_rd || w_accept_wr) begin
                r_op   <= w_accept_wr ? OP_WRITE : OP_READ;
                r_base <= {bus.ca_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            end
            if (w_accept_wr) r_wline <= bus.ca_wdata;
            // Cleared up front so words an aborted fill never reaches read back as zero.
            if (w_accept_rd) r_rdata <= '0;
            if (w_beat_done && (r_op == OP_READ))
                r_rdata[int'(w_beat)*WORD_W +: WORD_W] <= bus.mm_rdata;
        end
    end

    assign bus.mm_req   = w_run;
    assign bus.mm_we    = w_run && (r_op == OP_WRITE);
    assign bus.mm_addr  = r_base + (ADDR_W'(w_beat) << WORD_OFF_W);
    assign bus.mm_wdata = r_wline[int'(w_beat)*WORD_W +: WORD_W];
    assign bus.ca_rdata = r_rdata;
    assign bus.ca_resp  = w_ca_resp;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_cache_mem_adapter.sv
// Bench for cache_mem_adapter: vector table, corner sequences and random lines vs. a memory model.
module tb_cache_mem_adapter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_mem_adapter_if bus ();

    cache_mem_adapter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wbase;
        int          w;
        int          dead;
        int          lat;
        bit          err;
    } vec_t;

    acc_t        acc_q[$];
    logic [31:0] mm_mem  [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          mem_wait = 0;
    int          mem_dead = -1;
    int          wcnt     = 0;
    int          rsp_beat;
    int          n_vec    = 0;
    int          n_miss   = 0;
    logic [255:0] m_rdata = '0;
    vec_t        tbl[8];

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        return mm_mem.exists(a) ? mm_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic int lat_of(input int w, input int d);
        return (d < 0) ? 1 + 8 * (w + 1) : 1 + d * (w + 1) + 255;
    endfunction

    // Memory responder: acks after mem_wait idle cycles per word, never on word mem_dead.
    always begin
        @(posedge clk);
        #1;
        if (!bus.mm_req) begin
            bus.mm_ack = 1'b0;
            wcnt       = 0;
        end else begin
            rsp_beat = int'(bus.mm_addr[4:2]);
            if (wcnt >= mem_wait && rsp_beat != mem_dead) begin
                bus.mm_ack = 1'b1;
                wcnt       = 0;
                acc_q.push_back('{bus.mm_we, bus.mm_addr, bus.mm_wdata});
                if (bus.mm_we) begin
                    mm_mem[bus.mm_addr] = bus.mm_wdata;
                    bus.mm_rdata        = 32'h0;
                end else begin
                    bus.mm_rdata = mem_get(bus.mm_addr);
                end
            end else begin
                bus.mm_ack   = 1'b0;
                bus.mm_rdata = 32'hDEAD_BEEF;
                wcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        int hits;
        hits = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.mm_req || bus.ca_resp) hits++;
        end
        check({tag, ".idle_quiet"}, hits, 0);
    endtask

    task automatic do_line(input bit is_wr, input logic [31:0] addr, input logic [31:0] wbase,
                           input int w, input int dead, input int exp_lat, input bit exp_err,
                           input string tag);
        logic [31:0]  base;
        logic [255:0] wl;
        int           resp_t;
        int           err_t;
        int           err_n;
        int           nbeats;
        base = {addr[31:5], 5'b0};
        for (int i = 0; i < 8; i++) wl[i*32 +: 32] = wbase + i;
        mem_wait = w;
        mem_dead = dead;
        acc_q.delete();
        bus.ca_addr   = addr;
        bus.ca_wdata  = wl;
        bus.mem_write = is_wr;
        bus.mem_read  = !is_wr;
        resp_t = -1;
        err_t  = -1;
        err_n  = 0;
        for (int t = 1; t <= 1000 && resp_t < 0; t++) begin
            tick();
            if (bus.err) begin
                err_n++;
                err_t = t;
            end
            if (bus.ca_resp) resp_t = t;
        end
        check({tag, ".resp_cycle"}, resp_t, exp_lat);
        check({tag, ".err_count"}, err_n, exp_err ? 1 : 0);
        if (exp_err) check({tag, ".err_cycle"}, err_t, exp_lat);

        nbeats = (dead < 0) ? 8 : dead;
        check({tag, ".beats"}, acc_q.size(), nbeats);
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            check({tag, ".addr"}, acc_q[i].addr, base + 32'(4 * i));
            check({tag, ".we"}, acc_q[i].we, is_wr);
            if (is_wr) check({tag, ".wdata"}, acc_q[i].data, wl[i*32 +: 32]);
        end

        if (is_wr) begin
            for (int i = 0; i < nbeats; i++) ref_mem[base + 32'(4 * i)] = wl[i*32 +: 32];
        end else begin
            m_rdata = '0;
            for (int i = 0; i < nbeats; i++) m_rdata[i*32 +: 32] = ref_get(base + 32'(4 * i));
        end
        for (int i = 0; i < 8; i++)
            check({tag, ".ca_rdata"}, bus.ca_rdata[i*32 +: 32], m_rdata[i*32 +: 32]);

        // Controller keeps its request one cycle past ca_resp before dropping it.
        tick();
        check({tag, ".resp_one_cycle"}, {bus.ca_resp, bus.mm_req}, 2'b00);
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.ca_addr   = '0;
        bus.ca_wdata  = '0;
        bus.mm_ack    = 1'b0;
        bus.mm_rdata  = '0;
        repeat (3) tick();

        check("reset.ctrl", {bus.mm_req, bus.mm_we, bus.ca_resp, bus.err}, 4'b0000);
        check("reset.mm_addr", bus.mm_addr, 32'h0);
        check("reset.mm_wdata", bus.mm_wdata, 32'h0);
        check("reset.ca_rdata_any", |bus.ca_rdata, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            mm_mem [32'h120 + 32'(4 * i)] = 32'h1000 + 32'(i);
            ref_mem[32'h120 + 32'(4 * i)] = 32'h1000 + 32'(i);
        end

        tbl[0] = '{1'b0, 32'h0000_0124, 32'h0,    0, -1,   9, 1'b0};
        tbl[1] = '{1'b1, 32'h0000_0124, 32'hA0,   3, -1,  33, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_013C, 32'h0,    1, -1,  17, 1'b0};
        tbl[3] = '{1'b1, 32'hFFFF_FFE4, 32'h5000, 0, -1,   9, 1'b0};
        tbl[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,    2, -1,  25, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0200, 32'h0,    0,  2, 258, 1'b1};
        tbl[6] = '{1'b1, 32'h0000_0300, 32'h77,   1,  0, 256, 1'b1};
        tbl[7] = '{1'b1, 32'h0000_0340, 32'h9000, 0,  5, 261, 1'b1};
        for (int v = 0; v < 8; v++) begin
            do_line(tbl[v].wr, tbl[v].addr, tbl[v].wbase, tbl[v].w, tbl[v].dead,
                    tbl[v].lat, tbl[v].err, $sformatf("vec%0d", v));
            idle_check(3, $sformatf("vec%0d", v));
        end

        // Write-back then fill with the fill request raised as the write request drops.
        do_line(1'b1, 32'h0000_0400, 32'hB0, 0, -1, 9, 1'b0, "wb_then_fill.wr");
        do_line(1'b0, 32'h0000_0400, 32'h0, 0, -1, 10, 1'b0, "wb_then_fill.rd");
        idle_check(4, "wb_then_fill.no_dup");

        // Conflicting requests in IDLE.
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        tick();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        check("both.err_pulse", {bus.err, bus.mm_req}, 2'b10);
        tick();
        check("both.err_clear", {bus.err, bus.mm_req}, 2'b00);
        do_line(1'b0, 32'h0000_0124, 32'h0, 0, -1, 9, 1'b0, "both.after_rd");
        idle_check(2, "both");

        // Reset while beat 4 of a write-back is on the bus.
        begin
            int t;
            int hits;
            for (int i = 0; i < 8; i++) bus.ca_wdata[i*32 +: 32] = 32'hC0 + 32'(i);
            bus.ca_addr   = 32'h0000_4000;
            mem_wait      = 0;
            mem_dead      = -1;
            acc_q.delete();
            bus.mem_write = 1'b1;
            t = 0;
            while (acc_q.size() < 5 && t < 50) begin
                tick();
                t++;
            end
            check("rst_mid.reach_beat4", acc_q.size(), 5);
            rst = 1'b1;
            tick();
            check("rst_mid.ctrl", {bus.mm_req, bus.mm_we, bus.ca_resp, bus.err}, 4'b0000);
            check("rst_mid.mm_addr", bus.mm_addr, 32'h0);
            check("rst_mid.mm_wdata", bus.mm_wdata, 32'h0);
            check("rst_mid.ca_rdata_any", |bus.ca_rdata, 1'b0);
            rst           = 1'b0;
            bus.mem_write = 1'b0;
            m_rdata       = '0;
            hits          = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (bus.ca_resp || bus.mm_req) hits++;
            end
            check("rst_mid.no_resp", hits, 0);
        end
        do_line(1'b0, 32'h0000_5000, 32'h0, 0, -1, 9, 1'b0, "rst_mid.after_rd");
        idle_check(1, "rst_mid");

        // Random lines against the memory model.
        for (int r = 0; r < 40; r++) begin
            bit          wr;
            logic [31:0] addr;
            int          w;
            int          d;
            wr   = 1'($urandom_range(0, 1));
            addr = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            w    = int'($urandom_range(0, 2));
            d    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            do_line(wr, addr, $urandom, w, d, lat_of(w, d), d >= 0, $sformatf("rnd%0d", r));
            idle_check(1, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
